// File: rtl/comb_gates_100b_deser.sv
// comb_gates_100b_deser: beat-to-word deserializer feeding the pairwise stage.
// Collects NBITS/CHUNK beats LSB-first, then holds the word until accepted.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   clear    - synchronous discard of partial or held word
//   in_val   - input beat valid
//   in_rdy   - input beat ready
//   in_      - input beat data, CHUNK bits
//   out_val  - assembled word valid
//   out_rdy  - consumer ready
//   out_     - assembled word; beat k sits at [k*CHUNK +: CHUNK]
module comb_gates_100b_deser #(
    parameter int NBITS = 100,
    parameter int CHUNK = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [CHUNK-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_
);

    localparam int NBEATS = NBITS / CHUNK;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    typedef enum logic {
        S_FILL,
        S_FULL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_idx;
    logic [NBITS-1:0] r_data;
    logic             w_beat_fire;
    logic             w_word_fire;
    logic             w_wr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr        = 1'b0;
        in_rdy      = 1'b1;
        out_val     = 1'b0;
        w_idx       = r_cnt;

        unique case (r_state)
            S_FILL: begin
                in_rdy  = 1'b1;
                out_val = 1'b0;
                w_idx   = r_cnt;
            end
            S_FULL: begin
                // A beat can only enter while the held word leaves,
                // and it then starts the next word at slice 0.
                in_rdy  = out_rdy;
                out_val = 1'b1;
                w_idx   = '0;
            end
        endcase

        w_beat_fire = in_val & in_rdy;
        w_word_fire = out_val & out_rdy;

        if (clear) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
        end else begin
            if (w_word_fire) begin
                w_state_nxt = S_FILL;
                w_cnt_nxt   = '0;
            end
            if (w_beat_fire) begin
                w_wr = 1'b1;
                if (w_idx == LAST) begin
                    w_state_nxt = S_FULL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_FILL;
                    w_cnt_nxt   = w_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Only the addressed slice is rewritten; other slices keep old bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < NBEATS; k++) begin
                if (w_wr && (w_idx == CW'(k))) begin
                    r_data[k*CHUNK +: CHUNK] <= in_;
                end
            end
        end
    end

    assign out_ = r_data;

endmodule

// File: tb/tb_comb_gates_100b_deser.sv
// tb_comb_gates_100b_deser: scoreboard bench for the beat deserializer.
// Directed scenarios followed by randomized traffic against a queue model.
module tb_comb_gates_100b_deser;

    localparam int NBITS  = 100;
    localparam int CHUNK  = 10;
    localparam int NBEATS = NBITS / CHUNK;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             in_val;
    logic             in_rdy;
    logic [CHUNK-1:0] in_;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_;

    comb_gates_100b_deser #(.NBITS(NBITS), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_    (out_)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NBITS-1:0] act,
                       input logic [NBITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beats accepted so far, and the word awaiting pickup.
    logic [CHUNK-1:0] m_beats[$];
    logic [NBITS-1:0] exp_q[$];
    bit               m_full = 1'b0;
    int               fire_cyc[$];

    always @(posedge clk or negedge reset_n) begin
        bit               rdy;
        logic [NBITS-1:0] w;
        if (!reset_n) begin
            m_beats.delete();
            exp_q.delete();
            m_full = 1'b0;
        end else if (clear) begin
            m_beats.delete();
            exp_q.delete();
            m_full = 1'b0;
        end else begin
            rdy = !m_full || (out_rdy === 1'b1);
            if (m_full && out_rdy === 1'b1) m_full = 1'b0;
            if (in_val === 1'b1 && rdy) begin
                m_beats.push_back(in_);
                if (m_beats.size() == NBEATS) begin
                    w = '0;
                    for (int k = 0; k < NBEATS; k++)
                        w = w | (NBITS'(m_beats[k]) << (k * CHUNK));
                    exp_q.push_back(w);
                    m_beats.delete();
                    m_full = 1'b1;
                end
            end
        end
    end

    // Monitor: compares handshake outputs and pops words as they leave.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("out_val", NBITS'(out_val), NBITS'(m_full));
            chk("in_rdy", NBITS'(in_rdy), NBITS'(!m_full || out_rdy === 1'b1));
            if (out_val === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", out_);
                end else begin
                    chk("word", out_, exp_q[0]);
                    if (out_rdy === 1'b1 && clear !== 1'b1) begin
                        void'(exp_q.pop_front());
                        fire_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [CHUNK-1:0] d,
                         input bit r, input bit c);
        @(posedge clk);
        #1;
        in_val  = v;
        in_     = d;
        out_rdy = r;
        clear   = c;
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NBITS-1:0] held;
        logic [NBITS-1:0] e155;
        logic [CHUNK-1:0] v155;
        reset_n = 1'b0;
        clear   = 1'b0;
        in_val  = 1'b0;
        in_     = '0;
        out_rdy = 1'b0;
        v155    = 10'h155;
        e155    = {10{v155}};

        #1;
        chk("rst_out_val", NBITS'(out_val), '0);
        chk("rst_in_rdy", NBITS'(in_rdy), NBITS'(1));
        chk("rst_out", out_, '0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // 1: ten all-ones beats, word one cycle after the last beat
        for (int k = 0; k < NBEATS; k++) drive(1'b1, 10'h3FF, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t1_val", NBITS'(out_val), NBITS'(1));
        chk("t1_and", NBITS'(&out_), NBITS'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // 2: beat k carries k, checked LSB-first
        for (int k = 0; k < NBEATS; k++)
            drive(1'b1, CHUNK'(k), 1'b0, 1'b0);
        drive(1'b1, CHUNK'($urandom), 1'b0, 1'b0);
        #1;
        for (int k = 0; k < NBEATS; k++)
            chk($sformatf("t2_slice%0d", k),
                NBITS'(out_[k*CHUNK +: CHUNK]), NBITS'(k));
        held = out_;

        // 3: back-pressure for 5 cycles, then word and beat fire together
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, CHUNK'($urandom), 1'b0, 1'b0);
            #1;
            chk("t3_in_rdy", NBITS'(in_rdy), '0);
            chk("t3_stable", out_, held);
        end
        drive(1'b1, 10'h2A, 1'b1, 1'b0);
        for (int k = 1; k < NBEATS; k++)
            drive(1'b1, CHUNK'(k + 100), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("t3_slice0", NBITS'(out_[CHUNK-1:0]), NBITS'(10'h2A));
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // 4: 30 beats streaming, words 10 cycles apart
        fire_cyc.delete();
        for (int k = 0; k < 3 * NBEATS; k++)
            drive(1'b1, CHUNK'($urandom), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("t4_words", NBITS'(fire_cyc.size()), NBITS'(3));
        if (fire_cyc.size() == 3) begin
            chk("t4_gap1", NBITS'(fire_cyc[1] - fire_cyc[0]), NBITS'(NBEATS));
            chk("t4_gap2", NBITS'(fire_cyc[2] - fire_cyc[1]), NBITS'(NBEATS));
        end

        // 5: clear discards partial beats
        for (int k = 0; k < 4; k++) drive(1'b1, CHUNK'($urandom), 1'b1, 1'b0);
        drive(1'b1, CHUNK'($urandom), 1'b1, 1'b1);
        for (int k = 0; k < NBEATS; k++) drive(1'b1, v155, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t5_val", NBITS'(out_val), NBITS'(1));
        chk("t5_word", out_, e155);
        drive(1'b0, '0, 1'b1, 1'b0);

        // 6: async reset mid-word
        for (int k = 0; k < 7; k++) drive(1'b1, CHUNK'($urandom), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_out_val", NBITS'(out_val), '0);
        chk("t6_in_rdy", NBITS'(in_rdy), NBITS'(1));
        #1 reset_n = 1'b1;
        for (int k = 0; k < NBEATS - 1; k++)
            drive(1'b1, CHUNK'($urandom), 1'b0, 1'b0);
        drive(1'b1, CHUNK'($urandom), 1'b0, 1'b0);
        #1;
        chk("t6_not_yet", NBITS'(out_val), '0);
        settle();
        chk("t6_full", NBITS'(out_val), NBITS'(1));

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            drive(($urandom % 4) != 0, CHUNK'($urandom),
                  ($urandom % 3) != 0, ($urandom % 60) == 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
